// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// The optional HAZARD_PERF_EN build adds performance counters in hazard_ctrl.
package hazard_pkg;

    localparam int REG_AW_DEF      = 5;
    localparam int MEM_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc;
        logic fd;
        logic de;
        logic em;
        logic mw;
    } hz_en_t;

    typedef struct packed {
        logic fd;
        logic de;
        logic em;
        logic mw;
    } hz_clr_t;

    // Register fields arrive zero-extended so one helper serves any REG_AW up to 32.
    function automatic logic ldu_detect(
        input logic        memread,
        input logic [31:0] rd,
        input logic [31:0] rs1,
        input logic [31:0] rs2
    );
        return memread && (rd != 32'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_wait_timer.sv
// Consecutive-wait counter with timeout compare; shared by the data-memory
// wait path and the I-cache miss path.
module hazard_wait_timer
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wcnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt <= '0;
        end else if (start) begin
            wcnt <= CW'(1);
        end else if (run) begin
            if (!expired) begin
                wcnt <= wcnt + CW'(1);
            end
        end else begin
            wcnt <= '0;
        end
    end

    assign expired = (wcnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory
// waits with a timeout watchdog. Define HAZARD_PERF_EN for stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              memread_e,
    input  logic              pcsrc_e,
    input  logic              mem_req_m,
    input  logic              mem_ready_m,
    output logic              en_pc,
    output logic              en_fd,
    output logic              en_de,
    output logic              en_em,
    output logic              en_mw,
    output logic              clr_fd,
    output logic              clr_de,
    output logic              clr_em,
    output logic              clr_mw,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count,
`endif
    output logic              mem_err
);

    hz_state_t state, state_nxt;
    hz_en_t    en;
    hz_clr_t   clr;
    logic      mstall;
    logic      ldu;
    logic      expired;

    assign mstall = mem_req_m & ~mem_ready_m;
    assign ldu    = ldu_detect(memread_e, 32'(rd_e), 32'(rs1_d), 32'(rs2_d));

    hazard_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .start   ((state == RUN) && mstall),
        .run     ((state == MEM_WAIT) && mstall),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaults are assigned before any branch so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mstall) state_nxt = MEM_WAIT;
            MEM_WAIT: begin
                if (!mstall) begin
                    state_nxt = RUN;
                end else if (expired) begin
                    state_nxt = ERROR;
                end
            end
            ERROR:    state_nxt = ERROR;
            default:  state_nxt = RUN;
        endcase
    end

    // Memory stall outranks everything; a branch held in the frozen Execute
    // stage is simply flushed on the first non-stalled cycle.
    always_comb begin
        en      = '1;
        clr     = '0;
        mem_err = 1'b0;
        if (!reset) begin
            en  = '0;
            clr = '1;
        end else if (state == ERROR) begin
            en      = '0;
            mem_err = 1'b1;
        end else if (mstall) begin
            en.pc  = 1'b0;
            en.fd  = 1'b0;
            en.de  = 1'b0;
            en.em  = 1'b0;
            clr.mw = 1'b1;
        end else if (pcsrc_e) begin
            clr.fd = 1'b1;
            clr.de = 1'b1;
        end else if (ldu) begin
            en.pc  = 1'b0;
            en.fd  = 1'b0;
            clr.de = 1'b1;
        end
    end

    assign en_pc  = en.pc;
    assign en_fd  = en.fd;
    assign en_de  = en.de;
    assign en_em  = en.em;
    assign en_mw  = en.mw;
    assign clr_fd = clr.fd;
    assign clr_de = clr.de;
    assign clr_em = clr.em;
    assign clr_mw = clr.mw;

`ifdef HAZARD_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = (state != ERROR) && (ldu || mstall);
    assign flush_evt = (state != ERROR) && pcsrc_e && !mstall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_evt && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush_evt && (flush_count != '1)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues expected control vectors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

    localparam int REG_AW      = 5;
    localparam int MEM_TIMEOUT = 4;

    localparam logic [4:0] EN_ALL   = 5'b11111;
    localparam logic [4:0] EN_NONE  = 5'b00000;
    localparam logic [4:0] EN_LDU   = 5'b00111;
    localparam logic [4:0] EN_MST   = 5'b00001;
    localparam logic [3:0] CLR_NONE = 4'b0000;
    localparam logic [3:0] CLR_ALL  = 4'b1111;
    localparam logic [3:0] CLR_LDU  = 4'b0100;
    localparam logic [3:0] CLR_BR   = 4'b1100;
    localparam logic [3:0] CLR_MST  = 4'b0001;

    typedef struct {
        string      name;
        logic [4:0] en;
        logic [3:0] clr;
        logic       err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] rs1_d, rs2_d, rd_e;
    logic              memread_e, pcsrc_e, mem_req_m, mem_ready_m;
    logic              en_pc, en_fd, en_de, en_em, en_mw;
    logic              clr_fd, clr_de, clr_em, clr_mw;
    logic              mem_err;
`ifdef HAZARD_PERF_EN
    logic [31:0]       stall_cycles, flush_count;
`endif

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_AW      (REG_AW),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd_e         (rd_e),
        .memread_e    (memread_e),
        .pcsrc_e      (pcsrc_e),
        .mem_req_m    (mem_req_m),
        .mem_ready_m  (mem_ready_m),
        .en_pc        (en_pc),
        .en_fd        (en_fd),
        .en_de        (en_de),
        .en_em        (en_em),
        .en_mw        (en_mw),
        .clr_fd       (clr_fd),
        .clr_de       (clr_de),
        .clr_em       (clr_em),
        .clr_mw       (clr_mw),
`ifdef HAZARD_PERF_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
`endif
        .mem_err      (mem_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic quiet();
        rs1_d       = '0;
        rs2_d       = '0;
        rd_e        = '0;
        memread_e   = 1'b0;
        pcsrc_e     = 1'b0;
        mem_req_m   = 1'b0;
        mem_ready_m = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [4:0] en, input logic [3:0] clr,
                              input logic err);
        exp_t e;
        e.name = nm;
        e.en   = en;
        e.clr  = clr;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".en"}, 32'({en_pc, en_fd, en_de, en_em, en_mw}), 32'(e.en));
                check({e.name, ".clr"}, 32'({clr_fd, clr_de, clr_em, clr_mw}), 32'(e.clr));
                check({e.name, ".err"}, 32'(mem_err), 32'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        quiet();

        // Reset, then quiet run
        cyc(); expect_out("rst0", EN_NONE, CLR_ALL, 1'b0);
        cyc(); expect_out("rst1", EN_NONE, CLR_ALL, 1'b0);
        cyc(); reset = 1'b1; expect_out("idle", EN_ALL, CLR_NONE, 1'b0);

        // Load-use detection
        cyc(); memread_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs2_d = 5'd0;
        expect_out("ldu_rs1", EN_LDU, CLR_LDU, 1'b0);
        cyc(); rs1_d = 5'd0; rs2_d = 5'd5;
        expect_out("ldu_rs2", EN_LDU, CLR_LDU, 1'b0);
        cyc(); rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
        expect_out("ldu_x0", EN_ALL, CLR_NONE, 1'b0);
        cyc(); rd_e = 5'd5; rs1_d = 5'd6; rs2_d = 5'd7;
        expect_out("ldu_nomatch", EN_ALL, CLR_NONE, 1'b0);
        cyc(); memread_e = 1'b0; rs1_d = 5'd5;
        expect_out("no_load", EN_ALL, CLR_NONE, 1'b0);

        // Branch flush, and branch beating an illegal load-use
        cyc(); quiet(); pcsrc_e = 1'b1;
        expect_out("branch", EN_ALL, CLR_BR, 1'b0);
        cyc(); memread_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
        expect_out("branch_ldu", EN_ALL, CLR_BR, 1'b0);
        cyc(); quiet(); mem_req_m = 1'b1; mem_ready_m = 1'b1;
        expect_out("mem_1cyc", EN_ALL, CLR_NONE, 1'b0);

        // Three-cycle memory wait with a branch held in Execute; ready arrives at wcnt==MEM_TIMEOUT-1
        for (int i = 0; i < 3; i++) begin
            cyc(); quiet(); mem_req_m = 1'b1; pcsrc_e = 1'b1;
            if (i == 1) begin
                memread_e = 1'b1; rd_e = 5'd2; rs1_d = 5'd2;
            end
            expect_out($sformatf("mstall_br%0d", i), EN_MST, CLR_MST, 1'b0);
        end
        cyc(); quiet(); mem_req_m = 1'b1; mem_ready_m = 1'b1; pcsrc_e = 1'b1;
        expect_out("mem_ready_br", EN_ALL, CLR_BR, 1'b0);
        cyc(); quiet(); expect_out("post_mem", EN_ALL, CLR_NONE, 1'b0);

        // Request dropped while waiting
        cyc(); mem_req_m = 1'b1; expect_out("drop_wait", EN_MST, CLR_MST, 1'b0);
        cyc(); mem_req_m = 1'b0; expect_out("req_drop", EN_ALL, CLR_NONE, 1'b0);

        // Reset mid-wait clears the count: a full 3-cycle wait afterwards must not time out
        cyc(); mem_req_m = 1'b1; expect_out("rw_wait0", EN_MST, CLR_MST, 1'b0);
        cyc(); expect_out("rw_wait1", EN_MST, CLR_MST, 1'b0);
        cyc(); reset = 1'b0; expect_out("rst_mid_wait", EN_NONE, CLR_ALL, 1'b0);
        cyc(); reset = 1'b1; mem_req_m = 1'b0; expect_out("rw_release", EN_ALL, CLR_NONE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(); mem_req_m = 1'b1; mem_ready_m = 1'b0;
            expect_out($sformatf("rw_again%0d", i), EN_MST, CLR_MST, 1'b0);
        end
        cyc(); mem_ready_m = 1'b1; expect_out("rw_done", EN_ALL, CLR_NONE, 1'b0);

        // Timeout: four stalled cycles, ERROR visible on the fifth
        for (int i = 0; i < 4; i++) begin
            cyc(); quiet(); mem_req_m = 1'b1;
            expect_out($sformatf("tmo_wait%0d", i), EN_MST, CLR_MST, 1'b0);
        end
        cyc(); expect_out("tmo_err", EN_NONE, CLR_NONE, 1'b1);
        cyc(); mem_ready_m = 1'b1; expect_out("err_sticky", EN_NONE, CLR_NONE, 1'b1);
        cyc(); quiet(); pcsrc_e = 1'b1; memread_e = 1'b1; rd_e = 5'd4; rs2_d = 5'd4;
        expect_out("err_sticky2", EN_NONE, CLR_NONE, 1'b1);
        cyc(); quiet(); reset = 1'b0; expect_out("err_reset", EN_NONE, CLR_ALL, 1'b0);
        cyc(); reset = 1'b1; expect_out("err_recover", EN_ALL, CLR_NONE, 1'b0);
        cyc(); mem_req_m = 1'b1; expect_out("rec_stall", EN_MST, CLR_MST, 1'b0);
        cyc(); mem_ready_m = 1'b1; expect_out("rec_ready", EN_ALL, CLR_NONE, 1'b0);

`ifdef HAZARD_PERF_EN
        // Counters: 3 stall cycles and 2 flushes after a fresh reset
        cyc(); quiet(); reset = 1'b0; expect_out("perf_rst", EN_NONE, CLR_ALL, 1'b0);
        cyc(); reset = 1'b1; expect_out("perf_idle", EN_ALL, CLR_NONE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(); mem_req_m = 1'b1; mem_ready_m = 1'b0;
            expect_out($sformatf("perf_st%0d", i), EN_MST, CLR_MST, 1'b0);
        end
        cyc(); mem_ready_m = 1'b1; expect_out("perf_rdy", EN_ALL, CLR_NONE, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(); quiet(); pcsrc_e = 1'b1;
            expect_out($sformatf("perf_br%0d", i), EN_ALL, CLR_BR, 1'b0);
        end
        cyc(); quiet(); expect_out("perf_end", EN_ALL, CLR_NONE, 1'b0);
        @(negedge clk);
        check("stall_cycles", stall_cycles, 32'd3);
        check("flush_count", flush_count, 32'd2);
`endif

        cyc(); quiet();
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
